// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit for a 5-stage pipeline: tracks the two instructions ahead of decode.
// Optional stall_count port/counter is built when HFU_STALL_COUNT_EN is defined.
module hazard_forward_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_valid,
   input  logic [4:0] dec_Rn,
   input  logic [4:0] dec_Rm,
   input  logic [4:0] dec_Rd,
   input  logic       dec_Reg2Loc,
   input  logic       dec_RegWrite,
   input  logic       dec_MemRead,
   input  logic       dec_Move,
   input  logic       flush,
   output logic [1:0] forwardCondA,
   output logic [1:0] forwardCondB,
   output logic       stall
`ifdef HFU_STALL_COUNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   localparam logic [1:0] KIND_ALU  = 2'd0;
   localparam logic [1:0] KIND_LOAD = 2'd1;
   localparam logic [1:0] KIND_MOV  = 2'd2;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_ALU     = 2'b01;
   localparam logic [1:0] FWD_WB      = 2'b10;
   localparam logic [1:0] FWD_MOV     = 2'b11;

   localparam logic [4:0] ZERO_REG = 5'd31;

   logic       s1_valid;
   logic [4:0] s1_dest;
   logic       s1_wr;
   logic [1:0] s1_kind;

   logic       s2_valid;
   logic [4:0] s2_dest;
   logic       s2_wr;
   logic [1:0] s2_kind;

   logic [4:0] src_a;
   logic [4:0] src_b;
   logic       s1_prod;
   logic       s2_prod;
   logic       a_hit_s1;
   logic       a_hit_s2;
   logic       b_hit_s1;
   logic       b_hit_s2;
   logic       load_hit;
   logic [1:0] dec_kind;

   function automatic logic [1:0] kind_of(input logic move, input logic mem_read);
      if (move)
         return KIND_MOV;
      else if (mem_read)
         return KIND_LOAD;
      else
         return KIND_ALU;
   endfunction

   // Youngest producer wins; a load in S1 yields no forward code (handled as a stall).
   function automatic logic [1:0] fwd_code(input logic hit_s1, input logic hit_s2,
                                           input logic [1:0] kind_s1);
      if (hit_s1) begin
         case (kind_s1)
            KIND_ALU: return FWD_ALU;
            KIND_MOV: return FWD_MOV;
            default:  return FWD_REGFILE;
         endcase
      end
      else if (hit_s2)
         return FWD_WB;
      else
         return FWD_REGFILE;
   endfunction

   assign dec_kind = kind_of(dec_Move, dec_MemRead);

   always_comb begin
      src_a = dec_Rn;
      src_b = dec_Reg2Loc ? dec_Rm : dec_Rd;

      s1_prod = s1_valid && s1_wr && (s1_dest != ZERO_REG);
      s2_prod = s2_valid && s2_wr && (s2_dest != ZERO_REG);

      a_hit_s1 = s1_prod && (src_a != ZERO_REG) && (src_a == s1_dest);
      a_hit_s2 = s2_prod && (src_a != ZERO_REG) && (src_a == s2_dest);
      b_hit_s1 = s1_prod && (src_b != ZERO_REG) && (src_b == s1_dest);
      b_hit_s2 = s2_prod && (src_b != ZERO_REG) && (src_b == s2_dest);

      load_hit = dec_valid && (s1_kind == KIND_LOAD) && (a_hit_s1 || b_hit_s1);
   end

   // Flush beats the load-use stall; reset forces everything quiet immediately.
   always_comb begin
      stall        = load_hit && !flush && !rst;
      forwardCondA = FWD_REGFILE;
      forwardCondB = FWD_REGFILE;
      if (dec_valid && !load_hit && !rst) begin
         forwardCondA = fwd_code(a_hit_s1, a_hit_s2, s1_kind);
         forwardCondB = fwd_code(b_hit_s1, b_hit_s2, s1_kind);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_dest  <= 5'd0;
         s1_wr    <= 1'b0;
         s1_kind  <= KIND_ALU;
         s2_valid <= 1'b0;
         s2_dest  <= 5'd0;
         s2_wr    <= 1'b0;
         s2_kind  <= KIND_ALU;
      end
      else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end
      else begin
         s2_valid <= s1_valid;
         s2_dest  <= s1_dest;
         s2_wr    <= s1_wr;
         s2_kind  <= s1_kind;
         if (stall) begin
            s1_valid <= 1'b0;
            s1_dest  <= 5'd0;
            s1_wr    <= 1'b0;
            s1_kind  <= KIND_ALU;
         end
         else begin
            s1_valid <= dec_valid;
            s1_dest  <= dec_Rd;
            s1_wr    <= dec_RegWrite;
            s1_kind  <= dec_kind;
         end
      end
   end

`ifdef HFU_STALL_COUNT_EN
   // Saturating count of stall cycles; stall is already low whenever flush is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_count <= 16'd0;
      else if (stall && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end
`endif

   // The bubble inserted by a stall guarantees a load never stalls decode twice.
   a_single_stall: assert property (@(posedge clk) disable iff (rst) stall |=> !stall);
   a_flush_no_stall: assert property (@(posedge clk) disable iff (rst) flush |-> !stall);
   a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
      !dec_valid |-> (forwardCondA == FWD_REGFILE && forwardCondB == FWD_REGFILE && !stall));

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have `clk`  in  1  sole clock, rising-edge.
REQ-002 SHALL have `rst`  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have `dec_valid`  in  1  decode-stage instruction valid.
REQ-004 SHALL have `dec_Rn`, `dec_Rm`, `dec_Rd`  in  5 each  decode-stage register fields.
REQ-005 SHALL have `dec_Reg2Loc`  in  1  source-B select: 1 = Rm, 0 = Rd (stores).
REQ-006 SHALL have `dec_RegWrite`, `dec_MemRead`, `dec_Move`  in  1 each  decode-stage producer class.
REQ-007 SHALL have `flush`  in  1  squash all tracked instructions.
REQ-008 SHALL have `forwardCondA`, `forwardCondB`  out  2 each  datapath mux selects.
  - 11 = mov_result; 10 = write-back data; 01 = ALU result; 00 = regfile.
REQ-009 SHALL have `stall`  out  1  hold fetch/decode and insert a bubble.

Function
REQ-010 SHALL track two older in-flight instructions.
  - Slots: S1 (one ahead of decode), S2 (two ahead).
  - Per slot: valid, dest[4:0], wr, kind ∈ {ALU, LOAD, MOV}.
REQ-011 SHALL derive slot kind on capture:
  - MOV if dec_Move = 1.
  - Else LOAD if dec_MemRead = 1.
  - Else ALU.
REQ-012 SHALL treat a slot as a producer only when valid = 1, wr = 1, and dest != 31.
REQ-013 SHALL use source A = dec_Rn and source B = (dec_Reg2Loc ? dec_Rm : dec_Rd).
  - A source equal to 31 never matches.
REQ-014 SHALL compute `forwardCondA`/`forwardCondB` combinationally from decode inputs and slot state, independently per source.
  - S1 producer match: ALU → 01; MOV → 11; LOAD → load-use (REQ-015).
  - Else S2 producer match, any kind → 10.
  - Else → 00.
  - S1 has priority over S2 (youngest wins).
REQ-015 SHALL assert `stall` = 1 when dec_valid = 1 and either source matches an S1 producer of kind LOAD.
  - During that stall, both forward codes = 00.
REQ-016 SHALL update slots on each rising edge as follows:
  - flush = 1: S1 and S2 invalid.
  - Else stall = 1: S2 ← S1; S1 ← bubble.
  - Else: S2 ← S1; S1 ← decode instruction (valid = dec_valid).
REQ-017 SHALL give flush priority over stall, and force `stall` = 0 in any cycle where flush = 1.
REQ-018 SHALL never assert `stall` for two consecutive cycles for the same load.
  - After the bubble, the load sits in S2 and the code becomes 10.
REQ-019 SHALL output 00 codes and `stall` = 0 whenever dec_valid = 0.

Reset
REQ-020 SHALL, while rst = 1, asynchronously clear S1/S2 valid bits, drive `forwardCondA` = `forwardCondB` = 00 and `stall` = 0.
  - This applies even when rst is asserted mid-stall.
REQ-021 SHALL resume tracking from the first rising edge after rst deasserts.

Configuration
REQ-022 SHALL, when macro `HFU_STALL_COUNT_EN` is defined, add port `stall_count`  out  16  count of cycles with `stall` = 1.
  - Cleared by rst.
  - Saturates at 16'hFFFF.
  - Does not increment when flush = 1.
REQ-023 SHALL, when `HFU_STALL_COUNT_EN` is undefined, omit the port and counter entirely, with no other behavioural change.

Verification
REQ-024 SHALL cover ALU back-to-back:
  - Stimulus: ADD X1 (RegWrite), then SUB using Rn = 1, Rm = 2.
  - Response: A = 01, B = 00, stall = 0.
REQ-025 SHALL cover load-use:
  - Stimulus: LDUR X3, then ADD Rn = 3.
  - Response: stall = 1 with codes 00 for one cycle; next cycle A = 10 and stall = 0.
REQ-026 SHALL cover priority and MOV:
  - Stimulus: MOVZ X5 in S2, ADD X5 in S1, then decode Rn = 5, Rm = 5.
  - Response: A = B = 01.
  - Repeat with MOVK X5 in S1: A = B = 11.
REQ-027 SHALL cover the zero register and store source:
  - Stimulus: ADD X31 in S1, decode Rn = 31 → A = 00.
  - Stimulus: ADD X7 in S1, STUR with Reg2Loc = 0 and Rd = 7 → B = 01.
REQ-028 SHALL cover flush and reset:
  - Stimulus: LDUR X4 in S1, flush = 1 with decode Rn = 4.
  - Response: stall = 0; next cycle A = 00.
  - Stimulus: assert rst mid-stall.
  - Response: stall falls immediately; with `HFU_STALL_COUNT_EN`, stall_count = 0.
